param_addsub_loader: RTL



---
 rtl/param_addsub_loader_pkg.sv | 14 +
 rtl/full_adder.sv | 13 +
 rtl/param_addsub_loader_addsub.sv | 33 +++
 rtl/param_addsub_loader.sv | 109 ++++++++++
 4 files changed

// File: rtl/param_addsub_loader_pkg.sv
// Shared encodings for the rotary-entry adder/subtractor: entry phases and mode bits.
package param_addsub_loader_pkg;

  typedef enum logic [1:0] {
    PH_LOAD_A    = 2'd0,
    PH_LOAD_B    = 2'd1,
    PH_LOAD_MODE = 2'd2,
    PH_SHOW      = 2'd3
  } phase_t;

  localparam int MODE_SUB = 0;
  localparam int MODE_SAT = 1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/param_addsub_loader_addsub.sv
// ripple_addsub: combinational WIDTH-bit two's-complement add/subtract built from full_adder cells.
module ripple_addsub #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] raw,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] b_eff;

  // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in.
  assign b_eff = b ^ {WIDTH{sub}};
  assign c[0]  = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b_eff[i]),
      .cin (c[i]),
      .s   (raw[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[WIDTH];
  assign ovf  = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/param_addsub_loader.sv
// Nibble-serial operand loader around ripple_addsub with optional signed saturation
// and a registered result.
//
//   state        | meaning
//   PH_LOAD_A    | each entry writes the next nibble of A, low nibble first
//   PH_LOAD_B    | each entry writes the next nibble of B
//   PH_LOAD_MODE | entry takes mode from X[1:0] and registers the result
//   PH_SHOW      | result held; next entry restarts at PH_LOAD_A
module param_addsub_loader
  import param_addsub_loader_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rotation_event,
  input  logic [3:0]       X,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             result_valid,
  output logic [1:0]       phase
);

  localparam int CHUNKS = (WIDTH + 3) / 4;
  localparam int IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDXW-1:0]     IDX_LAST = IDXW'(CHUNKS - 1);
  localparam logic [4*CHUNKS-1:0] NIB0     = '1 >> (4 * CHUNKS - 4);

  phase_t          st;
  logic            prev_ev;
  logic [IDXW-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] chunk_mask, chunk_data;
  logic [WIDTH-1:0] raw, sat_val, res;
  logic            raw_cout, raw_ovf, entry;

  assign entry = rotation_event & ~prev_ev;

  // Truncating to WIDTH drops the unused upper bits of X on the top chunk.
  assign chunk_mask = WIDTH'(NIB0 << {idx, 2'b00});
  assign chunk_data = WIDTH'({CHUNKS{X}});

  ripple_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (a_q),
    .b   (b_q),
    .sub (X[MODE_SUB]),
    .raw (raw),
    .cout(raw_cout),
    .ovf (raw_ovf)
  );

  // On overflow the true result lies beyond the range on A's side.
  assign sat_val = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
  assign res     = (X[MODE_SAT] && raw_ovf) ? sat_val : raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ev      <= 1'b1;
      st           <= PH_LOAD_A;
      idx          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum          <= '0;
      carry_out    <= 1'b0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      prev_ev <= rotation_event;
      if (entry) begin
        unique case (st)
          PH_LOAD_A: begin
            a_q <= (a_q & ~chunk_mask) | (chunk_data & chunk_mask);
            if (idx == IDX_LAST) begin
              idx <= '0;
              st  <= PH_LOAD_B;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          PH_LOAD_B: begin
            b_q <= (b_q & ~chunk_mask) | (chunk_data & chunk_mask);
            if (idx == IDX_LAST) begin
              idx <= '0;
              st  <= PH_LOAD_MODE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          PH_LOAD_MODE: begin
            sum          <= res;
            carry_out    <= raw_cout;
            overflow     <= raw_ovf;
            result_valid <= 1'b1;
            st           <= PH_SHOW;
          end
          PH_SHOW: begin
            idx          <= '0;
            result_valid <= 1'b0;
            st           <= PH_LOAD_A;
          end
        endcase
      end
    end
  end

  assign phase = st;

endmodule
